// File: rtl/asap1_pkg.sv
// Shared front-panel constants: button channel indices and the default debounce length.
package asap1_pkg;

    localparam int BTN_START_STOP = 0;
    localparam int BTN_STEP       = 1;
    localparam int BTN_SPEED      = 2;
    localparam int BTN_COUNT      = 3;

    // 10 ms at a 25 MHz clk_i.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw front-panel pins and the conditioned level/pulse outputs.
interface button_conditioner_if
    import asap1_pkg::*;
#(
    parameter int N_BTN = BTN_COUNT
);

    // No handshake: btn_press_o / btn_release_o are single-cycle strobes, valid for exactly
    // the one clk_i cycle they are high; btn_level_o is a level that is always valid.
    logic [N_BTN-1:0] btn_raw_i;
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;

    modport master (
        output btn_raw_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_release_o
    );

    modport slave (
        input  btn_raw_i,
        output btn_level_o,
        output btn_press_o,
        output btn_release_o
    );

endinterface

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, saturating-by-accept debounce counter, stable level
// and registered press/release strobes.
module debounce_channel
    import asap1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;
    logic          rel_q;

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            // Any return to the accepted level restarts the count, so bounce never half-accepts.
            if (sync_q2 == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q < CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
                press_q  <= sync_q2;
                rel_q    <= ~sync_q2;
            end
        end
    end

    assign level = stable_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel conditioner: N_BTN independent debounce channels feeding clock_module's
// start/stop, step and speed controls.
module button_conditioner
    import asap1_pkg::*;
#(
    parameter int N_BTN           = BTN_COUNT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst,
    button_conditioner_if.slave btn
);

    logic [N_BTN-1:0] raw_pressed;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] rel_w;

    // Normalise polarity before the synchroniser so "pressed" is 1 and reset means released.
    assign raw_pressed = BTN_ACTIVE_LOW ? ~btn.btn_raw_i : btn.btn_raw_i;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i(clk_i),
            .rst  (rst),
            .raw  (raw_pressed[i]),
            .level(level_w[i]),
            .press(press_w[i]),
            .rel  (rel_w[i])
        );
    end

    assign btn.btn_level_o   = level_w;
    assign btn.btn_press_o   = press_w;
    assign btn.btn_release_o = rel_w;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-panel input stage that sits directly upstream of clock_module.
- Takes raw, bouncy, asynchronous pushbutton inputs (start/stop, step, speed) and synchronises each one to clk_i.
- Debounces each input, then produces a clean level and single-cycle press/release pulses.
- Level and pulse outputs drive clock_module's clk_start_stop_i, clk_step_i and clk_speed_i, so that one physical press yields exactly one event.

Parameters:
- N_BTN, 3, number of independent button channels. Bit 0 = start/stop, bit 1 = step, bit 2 = speed.
- DEBOUNCE_CYCLES, 250000, consecutive clk_i cycles the synchronised input must hold a new value before it is accepted. Legal range is 2 or more; 250000 gives 10 ms at 25 MHz.
- BTN_ACTIVE_LOW, 0, when 1, raw inputs are inverted at the input so that "pressed" is always 1 internally.

Ports:
- clk_i  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- btn_raw_i  input  N_BTN  raw pushbutton pins, asynchronous to clk_i
- btn_level_o  output  N_BTN  debounced level, 1 = pressed
- btn_press_o  output  N_BTN  one clk_i-cycle pulse on an accepted 0->1 transition
- btn_release_o  output  N_BTN  one clk_i-cycle pulse on an accepted 1->0 transition

Behaviour:
- Reset:
  - rst low asynchronously clears all state: sync flops, stable level, counters and pulse registers all go to 0.
  - While rst is low, all outputs are 0.
  - Reset deassertion is used directly (not resynchronised in this block).
- Synchroniser: each channel has a two-flop synchroniser. Its flops reset to 0, the "released" value after the optional inversion.
- Debounce, per channel, all updates on posedge clk_i:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If the synchroniser output equals stable, the counter clears to 0.
  - If it differs and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If it differs and counter == DEBOUNCE_CYCLES-1:
    - stable <= synchroniser output;
    - counter <= 0;
    - btn_press_o is set high for one cycle if the new value is 1, otherwise btn_release_o is set high for one cycle.
- Glitches and bounce: any return to equality before the count completes restarts the count from 0. A bounce therefore never produces a partial accept.
- Latency:
  - Let raw change to a steady new value and be first sampled at edge k.
  - btn_level_o changes, and the matching pulse asserts, in the cycle after edge k+1+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 cycles.
- Pulse timing: each pulse is registered and lasts exactly one cycle. press and release are never high together on one channel.
- Channel independence: channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Counter boundary: the counter never wraps. It saturates only via the accept path.
- Button held through reset: if a button is held pressed through reset deassertion, it is treated as a new press. A btn_press_o pulse fires DEBOUNCE_CYCLES+2 cycles after rst rises.
- Reset mid-count: reset during a count discards that count. No pulse is emitted later for the aborted transition.
- Outputs are glitch-free registers with no combinational path from btn_raw_i.

Decomposition:
- Shared package asap1_pkg holds:
  - BTN_START_STOP=0, BTN_STEP=1, BTN_SPEED=2, BTN_COUNT=3;
  - DEBOUNCE_CYCLES_DEFAULT.
- One sub-module, debounce_channel, contains the synchroniser, counter, stable register and pulse registers for a single bit.
- button_conditioner instantiates N_BTN copies of it via generate and applies BTN_ACTIVE_LOW inversion at its inputs.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset:
  - Stimulus: hold rst=0 with btn_raw_i=3'b111.
  - Required: all outputs stay 0.
  - Stimulus: release rst with raw still held.
  - Required: btn_press_o=3'b111 for exactly one cycle, 6 cycles after rst rises; btn_level_o=3'b111 thereafter.
- Clean press on step:
  - Stimulus: btn_raw_i[1] goes 0->1 and is held.
  - Required: btn_press_o[1] pulses once, 6 cycles after the first sampling edge; btn_level_o[1]=1; bits 0 and 2 are unchanged.
- Bounce:
  - Stimulus: btn_raw_i[0] toggles 1,0,1,0,1 with 2 cycles per level, then holds 1.
  - Required: exactly one btn_press_o[0] pulse, timed 6 cycles after the final 0->1.
- Short glitch:
  - Stimulus: btn_raw_i[2] is high for 3 cycles, then low.
  - Required: no pulse on btn_press_o[2] or btn_release_o[2], and btn_level_o[2] stays 0.
- Release:
  - Stimulus: a pressed button returns to 0 and holds.
  - Required: btn_release_o pulses once for one cycle; btn_level_o drops in the same cycle; no press pulse.
- Reset mid-count:
  - Stimulus: assert rst low 2 cycles into a count, then deassert with raw=0.
  - Required: no pulses at any point; all outputs remain 0.
